// File: rtl/rover_pkg.sv
// Shared constants for the rover drive sequencer: motor command words,
// FSM state encoding and inductive sensor bit positions.
package rover_pkg;

  localparam logic [3:0] STOP  = 4'b0000;
  localparam logic [3:0] FWD   = 4'b0110;
  localparam logic [3:0] REV   = 4'b1001;
  localparam logic [3:0] LEFT  = 4'b1010;
  localparam logic [3:0] RIGHT = 4'b0101;

  // The low three bits form the debug code; HALT aliases IDLE there and is
  // told apart by the fault flag.
  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    FOLLOW      = 4'd1,
    AVOID_STOP  = 4'd2,
    AVOID_REV   = 4'd3,
    AVOID_PIVOT = 4'd4,
    AVOID_ARC   = 4'd5,
    REACQUIRE   = 4'd6,
    SEARCH      = 4'd7,
    HALT        = 4'd8
  } state_e;

  typedef enum logic {
    TURN_LEFT  = 1'b0,
    TURN_RIGHT = 1'b1
  } turn_e;

  localparam int IND_W      = 3;
  localparam int IND_LEFT   = 2;
  localparam int IND_CENTRE = 1;
  localparam int IND_RIGHT  = 0;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [3:0] turn_cmd(input turn_e t);
    return (t == TURN_RIGHT) ? RIGHT : LEFT;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a per-bit stability counter; a filtered
// bit flips only after DEBOUNCE_CYCLES consecutive differing samples.
module sensor_debounce #(
  parameter int WIDTH           = 1,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] filt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic [1:0][WIDTH-1:0] sync;

  always_ff @(posedge clk) begin
    if (reset) sync <= '0;
    else       sync <= {sync[0], raw};
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CW-1:0] cnt;
    logic          f;

    // Any sample matching the current filtered value restarts the run.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt <= '0;
        f   <= 1'b0;
      end else if (sync[1][i] == f) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt <= '0;
        f   <= sync[1][i];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign filt[i] = f;
  end

endmodule

// File: rtl/rover_drive_sequencer.sv
// Arbitrated, registered motor command source: line following, timed
// obstacle manoeuvre with retry limit, and line-loss search with timeout.
module rover_drive_sequencer
  import rover_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STOP_CYCLES     = 8,
  parameter int REV_CYCLES      = 16,
  parameter int PIVOT_CYCLES    = 12,
  parameter int ARC_CYCLES      = 32,
  parameter int SEARCH_TIMEOUT  = 64,
  parameter int MAX_RETRY       = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] induct,
  input  logic       proxim,
  output logic [3:0] motor_cmd,
  output logic       busy,
  output logic       fault,
  output logic [2:0] state_o
);

  localparam int MAX_DWELL = max2(max2(max2(STOP_CYCLES, REV_CYCLES),
                                       max2(PIVOT_CYCLES, ARC_CYCLES)),
                                  SEARCH_TIMEOUT);
  localparam int CNT_W = $clog2(MAX_DWELL) + 1;
  localparam int RW    = $clog2(MAX_RETRY + 1) + 1;

  logic [IND_W-1:0] ind_f;
  logic             prox_f;

  sensor_debounce #(.WIDTH(IND_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_induct_db (
    .clk  (clk),
    .reset(reset),
    .raw  (induct),
    .filt (ind_f)
  );

  sensor_debounce #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_proxim_db (
    .clk  (clk),
    .reset(reset),
    .raw  (proxim),
    .filt (prox_f)
  );

  state_e           state, state_n;
  logic [3:0]       cmd_n;
  turn_e            last_turn, last_turn_n;
  logic [RW-1:0]    retry, retry_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             line;

  // Loaded so that the state is left on the edge where the count reads 0,
  // giving exactly N cycles of residence.
  function automatic logic [CNT_W-1:0] entry_count(input state_e s);
    case (s)
      AVOID_STOP:        return CNT_W'(STOP_CYCLES - 1);
      AVOID_REV:         return CNT_W'(REV_CYCLES - 1);
      AVOID_PIVOT:       return CNT_W'(PIVOT_CYCLES - 1);
      AVOID_ARC:         return CNT_W'(ARC_CYCLES - 1);
      REACQUIRE, SEARCH: return CNT_W'(SEARCH_TIMEOUT - 1);
      default:           return '0;
    endcase
  endfunction

  assign line = |ind_f;

  always_comb begin
    state_n     = state;
    cmd_n       = motor_cmd;
    last_turn_n = last_turn;
    retry_n     = retry;
    cnt_n       = (cnt != '0) ? cnt - 1'b1 : cnt;

    case (state)
      IDLE:        if (enable) state_n = FOLLOW;
      FOLLOW: begin
        if (prox_f) begin
          state_n = AVOID_STOP;
          retry_n = '0;
        end else if (!line) begin
          state_n = SEARCH;
        end
      end
      AVOID_STOP:  if (cnt == '0) state_n = AVOID_REV;
      AVOID_REV:   if (cnt == '0) state_n = AVOID_PIVOT;
      AVOID_PIVOT: if (cnt == '0) state_n = AVOID_ARC;
      AVOID_ARC, REACQUIRE: begin
        if (prox_f) begin
          if (retry == RW'(MAX_RETRY)) begin
            state_n = HALT;
          end else begin
            state_n = AVOID_STOP;
            retry_n = retry + 1'b1;
          end
        end else if (state == REACQUIRE && line) begin
          state_n = FOLLOW;
        end else if (cnt == '0) begin
          state_n = (state == AVOID_ARC) ? REACQUIRE : HALT;
        end
      end
      SEARCH: begin
        if (prox_f) begin
          state_n = AVOID_STOP;
          retry_n = '0;
        end else if (line) begin
          state_n = FOLLOW;
        end else if (cnt == '0) begin
          state_n = HALT;
        end
      end
      HALT:        state_n = HALT;
      default:     state_n = IDLE;
    endcase

    if (!enable) begin
      state_n = IDLE;
      retry_n = '0;
    end

    if (state_n != state) cnt_n = entry_count(state_n);

    // Command is chosen for the state being entered so it lines up with it.
    case (state_n)
      FOLLOW: begin
        case (ind_f)
          3'b010, 3'b111: cmd_n = FWD;
          3'b100, 3'b110: begin cmd_n = LEFT;  last_turn_n = TURN_LEFT;  end
          3'b001, 3'b011: begin cmd_n = RIGHT; last_turn_n = TURN_RIGHT; end
          default:        cmd_n = motor_cmd;
        endcase
      end
      AVOID_REV:   cmd_n = REV;
      AVOID_PIVOT: cmd_n = RIGHT;
      AVOID_ARC:   cmd_n = LEFT;
      REACQUIRE:   cmd_n = FWD;
      SEARCH:      cmd_n = turn_cmd(last_turn);
      default:     cmd_n = STOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      motor_cmd <= STOP;
      last_turn <= TURN_LEFT;
      retry     <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_n;
      motor_cmd <= cmd_n;
      last_turn <= last_turn_n;
      retry     <= retry_n;
      cnt       <= cnt_n;
    end
  end

  assign busy    = (state == AVOID_STOP) || (state == AVOID_REV) ||
                   (state == AVOID_PIVOT) || (state == AVOID_ARC) ||
                   (state == REACQUIRE);
  assign fault   = (state == HALT);
  assign state_o = state[2:0];

endmodule

// File: tb/tb_rover_drive_sequencer.sv
// Directed bench for rover_drive_sequencer with hand-computed expectations.
module tb_rover_drive_sequencer;

  localparam logic [2:0] S_IDLE = 3'd0, S_FOLLOW = 3'd1, S_ASTOP = 3'd2,
                         S_AREV = 3'd3, S_APIV = 3'd4, S_AARC = 3'd5,
                         S_REACQ = 3'd6, S_SEARCH = 3'd7, S_HALT = 3'd0;
  localparam logic [3:0] C_STOP = 4'b0000, C_FWD = 4'b0110, C_REV = 4'b1001,
                         C_LEFT = 4'b1010, C_RIGHT = 4'b0101;

  logic       clk = 1'b0;
  logic       reset, enable, proxim;
  logic [2:0] induct;
  logic [3:0] motor_cmd;
  logic       busy, fault;
  logic [2:0] state_o;
  int         total = 0;
  int         bad   = 0;

  rover_drive_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .induct   (induct),
    .proxim   (proxim),
    .motor_cmd(motor_cmd),
    .busy     (busy),
    .fault    (fault),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] st, input logic [3:0] c,
                         input logic b, input logic f);
    chk({tag, ".state"}, {1'b0, state_o}, {1'b0, st});
    chk({tag, ".cmd"},   motor_cmd, c);
    chk({tag, ".busy"},  {3'b0, busy}, {3'b0, b});
    chk({tag, ".fault"}, {3'b0, fault}, {3'b0, f});
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; induct = 3'b000; proxim = 1'b0;
    step(3);
    chk_all("reset", S_IDLE, C_STOP, 1'b0, 1'b0);

    // Start-up: line not yet filtered, so FOLLOW drops into SEARCH first.
    reset = 1'b0; enable = 1'b1; induct = 3'b010;
    step(1); chk_all("start.e1", S_FOLLOW, C_STOP, 1'b0, 1'b0);
    step(1); chk_all("start.e2", S_SEARCH, C_LEFT, 1'b0, 1'b0);
    step(4); chk("start.e6.cmd", motor_cmd, C_LEFT);
    step(1); chk_all("start.e7", S_FOLLOW, C_FWD, 1'b0, 1'b0);

    // Line following.
    induct = 3'b100;
    step(6); chk("left.e6", motor_cmd, C_FWD);
    step(1); chk_all("left.e7", S_FOLLOW, C_LEFT, 1'b0, 1'b0);
    induct = 3'b000;
    step(7); chk_all("lost.e7", S_SEARCH, C_LEFT, 1'b0, 1'b0);
    induct = 3'b001;
    step(7); chk_all("right.e7", S_FOLLOW, C_RIGHT, 1'b0, 1'b0);
    induct = 3'b010;
    step(7); chk("centre.e7", motor_cmd, C_FWD);

    // Three-cycle glitch must not get through the filter.
    induct = 3'b110;
    for (int i = 0; i < 12; i++) begin
      step(1);
      chk("glitch.cmd", motor_cmd, C_FWD);
      if (i == 2) induct = 3'b010;
    end

    // Obstacle manoeuvre from a 10-cycle proximity pulse.
    proxim = 1'b1;
    step(7);  chk_all("avoid.stop.in", S_ASTOP, C_STOP, 1'b1, 1'b0);
    induct = 3'b000;
    step(3);  proxim = 1'b0;
    step(4);  chk_all("avoid.stop.last", S_ASTOP, C_STOP, 1'b1, 1'b0);
    step(1);  chk_all("avoid.rev.in", S_AREV, C_REV, 1'b1, 1'b0);
    step(15); chk_all("avoid.rev.last", S_AREV, C_REV, 1'b1, 1'b0);
    step(1);  chk_all("avoid.pivot.in", S_APIV, C_RIGHT, 1'b1, 1'b0);
    step(11); chk_all("avoid.pivot.last", S_APIV, C_RIGHT, 1'b1, 1'b0);
    step(1);  chk_all("avoid.arc.in", S_AARC, C_LEFT, 1'b1, 1'b0);
    step(31); chk_all("avoid.arc.last", S_AARC, C_LEFT, 1'b1, 1'b0);
    step(1);  chk_all("reacq.in", S_REACQ, C_FWD, 1'b1, 1'b0);
    step(5);  induct = 3'b010;
    step(6);  chk_all("reacq.hold", S_REACQ, C_FWD, 1'b1, 1'b0);
    step(1);  chk_all("reacq.found", S_FOLLOW, C_FWD, 1'b0, 1'b0);

    // Obstacle held through every arc: third re-hit faults.
    proxim = 1'b1;
    step(7);  chk_all("retry.stop0", S_ASTOP, C_STOP, 1'b1, 1'b0);
    step(36); chk_all("retry.arc0", S_AARC, C_LEFT, 1'b1, 1'b0);
    step(1);  chk_all("retry.stop1", S_ASTOP, C_STOP, 1'b1, 1'b0);
    step(73); chk_all("retry.arc2", S_AARC, C_LEFT, 1'b1, 1'b0);
    step(1);  chk_all("retry.halt", S_HALT, C_STOP, 1'b0, 1'b1);
    step(5);  chk_all("retry.halt.stays", S_HALT, C_STOP, 1'b0, 1'b1);
    enable = 1'b0; proxim = 1'b0;
    step(1);  chk_all("retry.disable", S_IDLE, C_STOP, 1'b0, 1'b0);
    step(8);

    // Search timeout: exactly 64 cycles in SEARCH, then HALT.
    enable = 1'b1;
    step(1);  chk_all("to.follow", S_FOLLOW, C_FWD, 1'b0, 1'b0);
    induct = 3'b000;
    step(7);  chk_all("to.search", S_SEARCH, C_RIGHT, 1'b0, 1'b0);
    step(63); chk_all("to.last", S_SEARCH, C_RIGHT, 1'b0, 1'b0);
    step(1);  chk_all("to.halt", S_HALT, C_STOP, 1'b0, 1'b1);
    enable = 1'b0; induct = 3'b010;
    step(8);  chk_all("to.idle", S_IDLE, C_STOP, 1'b0, 1'b0);

    // Line back on the final search cycle beats the timeout.
    enable = 1'b1;
    step(1);  chk_all("race.follow", S_FOLLOW, C_FWD, 1'b0, 1'b0);
    induct = 3'b000;
    step(7);  chk_all("race.search", S_SEARCH, C_RIGHT, 1'b0, 1'b0);
    step(57); induct = 3'b010;
    step(6);  chk_all("race.last", S_SEARCH, C_RIGHT, 1'b0, 1'b0);
    step(1);  chk_all("race.found", S_FOLLOW, C_FWD, 1'b0, 1'b0);

    // Reset in the middle of a manoeuvre.
    proxim = 1'b1;
    step(12); chk_all("rst.mid.pre", S_ASTOP, C_STOP, 1'b1, 1'b0);
    reset = 1'b1;
    step(1);  chk_all("rst.mid", S_IDLE, C_STOP, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
